mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared single-memory MIPS datapath. It replaces the single-cycle decode-only controller.
- It steps each instruction through fetch, decode, execute, memory and writeback. One ALU and one memory port are shared across cycles.
- It handles a ready handshake with the unified instruction/data memory.
- It also keeps a retired-instruction counter for the test bench and the debug path.

Parameters:
- TRAP_ON_ILLEGAL, default 1. 1 means an unknown opcode locks the FSM in ILLEGAL. 0 means the unknown instruction is treated as a nop.
- CNT_W, default 32. Width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; only valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 means store
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR and MDR
- pc_we  out  1  PC write enable
- pc_src  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr_index, 00}, 11 = rs
- reg_we  out  1  register file write enable
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31
- wd_sel  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = ext(imm), 11 = sext(imm) << 2
- alu_ctrl  out  3  ALU operation: 000 add, 001 sub, 010 or, 011 lui
- ext_sign  out  1  1 means sign-extend imm, 0 means zero-extend
- retire  out  1  one-cycle pulse when an instruction completes
- instr_cnt  out  CNT_W  count of retired instructions
- illegal  out  1  high while the FSM is in ILLEGAL
- state  out  4  current state, for debug

Behaviour:
- The FSM is Moore. Outputs decode from the state register; the exceptions are pc_we (gated by zero in BEQ) and ir_we / pc_we in FETCH (gated by mem_ready).
- Any output not listed for a state is 0.
- Reset (reset low):
  - state is forced to FETCH, instr_cnt to 0, all outputs to 0, immediately and asynchronously.
  - An in-flight memory request is dropped at once.
  - After reset releases, the first active edge behaves as FETCH.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add.
  - If mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=00, next state DECODE.
  - Otherwise stay in FETCH with no write strobes. There is no timeout.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, add. ALUOut is loaded with the branch target.
  - op/func are sampled only here. Next state by opcode:
    - op=000000 with func=100001 (addu) or 100011 (subu): EXEC_R
    - op=000000 with func=001000 (jr): JR
    - op=000000 with func=000000 (nop): FETCH, retire=1
    - op=001101 (ori) or 001111 (lui): EXEC_I
    - op=100011 (lw) or 101011 (sw): MEM_ADDR
    - op=000100 (beq): BEQ
    - op=000011 (jal): JAL
    - anything else: ILLEGAL if TRAP_ON_ILLEGAL, otherwise FETCH with retire=1
- EXEC_R: alu_src_a=1, alu_src_b=00, add or sub. Next state WB_R.
- WB_R: reg_we=1, reg_dst=01, wd_sel=00, retire=1. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_sign=0, or (ori) / lui. Next state WB_I.
- WB_I: reg_we=1, reg_dst=00, wd_sel=00, retire=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sign=1, add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_addr_sel=1. On mem_ready: ir_we is not asserted, MDR loads, next state MEM_WB. Otherwise hold.
- MEM_WB: reg_we=1, reg_dst=00, wd_sel=01, retire=1. Next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready: retire=1, next state FETCH. Otherwise hold.
- BEQ: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_we=zero, retire=1. Next state FETCH.
- JAL: reg_we=1, reg_dst=10, wd_sel=10 (PC already holds PC+4), pc_we=1, pc_src=10, retire=1. Next state FETCH.
- JR: pc_we=1, pc_src=11, retire=1. Next state FETCH.
- ILLEGAL: illegal=1, no strobes. Terminal until reset.
- Counter:
  - instr_cnt increments on every cycle with retire=1 and wraps modulo 2^CNT_W.
- Boundary rules:
  - mem_ready while mem_req=0 is ignored.
  - mem_ready may stay high continuously, giving the minimum latencies: nop 2 cycles; R/I/beq/jal/jr/sw 3–4 cycles; lw 5 cycles.
  - State encoding is one-hot-free binary in 4 bits. Unused codes go to FETCH.

Decomposition:
- Shared package mc_defs holds:
  - opcode and func constants
  - the 14 state codes
  - ALU, pc_src, reg_dst, wd_sel and alu_src_b code constants
- One sub-module, mc_decode: combinational op/func to instruction class (R_ALU, JR, NOP, I_ALU, LOAD, STORE, BEQ, JAL, BAD).

Test Plan:
- addu with mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_we=1 and reg_dst=01 only in WB_R; instr_cnt 0→1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_req=1, mem_addr_sel=1 held 4 cycles; MEM_WB then asserts wd_sel=01; total 8 cycles.
- beq with zero=1, then a second beq with zero=0 -> pc_we=1 then 0 in BEQ; both pulse retire.
- jal followed by jr -> JAL: reg_dst=10, wd_sel=10, pc_src=10; JR: pc_src=11; each takes 3 cycles.
- op=111111 with TRAP_ON_ILLEGAL=1 -> illegal=1 and state held for 20 cycles; reset low then high -> FETCH with instr_cnt=0. Same op with TRAP_ON_ILLEGAL=0 -> FETCH, retire=1.
- reset asserted mid-MEM_WR with mem_req=1 -> mem_req and mem_we drop in the same cycle; no retire; FETCH after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, states and datapath select codes.
package mc_defs;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    // Function field IR[5:0] for OP_SPECIAL
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_NOP  = 6'b000000;

    // Controller states, dense binary encoding; codes 14 and 15 are unused
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_R_ALU = 4'd0,
        CLS_JR    = 4'd1,
        CLS_NOP   = 4'd2,
        CLS_I_ALU = 4'd3,
        CLS_LOAD  = 4'd4,
        CLS_STORE = 4'd5,
        CLS_BEQ   = 4'd6,
        CLS_JAL   = 4'd7,
        CLS_BAD   = 4'd8
    } iclass_t;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    // Next-PC sources
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // Destination register selects
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register write-data selects
    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    // ALU B-input selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/function decoder: classifies the instruction and flags the second
// variant inside a class (subu vs addu, lui vs ori, sw vs lw).
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_t    o_class,
    output logic       o_variant
);

    // Map op/func onto an instruction class; anything unrecognised is BAD
    always_comb begin
        o_class   = CLS_BAD;
        o_variant = 1'b0;
        case (i_op)
            OP_SPECIAL: begin
                case (i_func)
                    FN_ADDU: o_class = CLS_R_ALU;
                    FN_SUBU: begin
                        o_class   = CLS_R_ALU;
                        o_variant = 1'b1;
                    end
                    FN_JR:   o_class = CLS_JR;
                    FN_NOP:  o_class = CLS_NOP;
                    default: o_class = CLS_BAD;
                endcase
            end
            OP_ORI: o_class = CLS_I_ALU;
            OP_LUI: begin
                o_class   = CLS_I_ALU;
                o_variant = 1'b1;
            end
            OP_LW:  o_class = CLS_LOAD;
            OP_SW: begin
                o_class   = CLS_STORE;
                o_variant = 1'b1;
            end
            OP_BEQ: o_class = CLS_BEQ;
            OP_JAL: o_class = CLS_JAL;
            default: o_class = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the shared-memory MIPS datapath, with a retired-instruction counter.
module mc_ctrl
    import mc_defs::*;
#(
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             ext_sign,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal,
    output logic [3:0]       state
);

    state_t           r_state;
    state_t           w_next;
    logic             r_variant;
    logic [CNT_W-1:0] r_instr_cnt;
    iclass_t          w_class;
    logic             w_variant;

    mc_decode u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_class   (w_class),
        .o_variant (w_variant)
    );

    // State register; reset drops straight back to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember the in-class variant while op/func are valid in DECODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_variant <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_variant <= w_variant;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_cnt <= '0;
        end else if (retire) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    // Next-state and output decode; outputs are forced low while reset is held
    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_ALU;
        reg_we       = 1'b0;
        reg_dst      = RD_RT;
        wd_sel       = WD_ALUOUT;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        alu_ctrl     = ALU_ADD;
        ext_sign     = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_ALU;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
                case (w_class)
                    CLS_R_ALU: w_next = S_EXEC_R;
                    CLS_JR:    w_next = S_JR;
                    CLS_NOP: begin
                        w_next = S_FETCH;
                        retire = 1'b1;
                    end
                    CLS_I_ALU: w_next = S_EXEC_I;
                    CLS_LOAD:  w_next = S_MEM_ADDR;
                    CLS_STORE: w_next = S_MEM_ADDR;
                    CLS_BEQ:   w_next = S_BEQ;
                    CLS_JAL:   w_next = S_JAL;
                    default: begin
                        if (TRAP_ON_ILLEGAL != 0) begin
                            w_next = S_ILLEGAL;
                        end else begin
                            w_next = S_FETCH;
                            retire = 1'b1;
                        end
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = r_variant ? ALU_SUB : ALU_ADD;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = RD_RD;
                wd_sel  = WD_ALUOUT;
                retire  = 1'b1;
                w_next  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = r_variant ? ALU_LUI : ALU_OR;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_we  = 1'b1;
                reg_dst = RD_RT;
                wd_sel  = WD_ALUOUT;
                retire  = 1'b1;
                w_next  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_sign  = 1'b1;
                w_next    = r_variant ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_we  = 1'b1;
                reg_dst = RD_RT;
                wd_sel  = WD_MDR;
                retire  = 1'b1;
                w_next  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_we     = zero;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                reg_we  = 1'b1;
                reg_dst = RD_RA;
                wd_sel  = WD_PC;
                pc_we   = 1'b1;
                pc_src  = PC_JUMP;
                retire  = 1'b1;
                w_next  = S_FETCH;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = PC_RS;
                retire = 1'b1;
                w_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = S_ILLEGAL;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        if (!reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 2'b00;
            reg_we       = 1'b0;
            reg_dst      = 2'b00;
            wd_sel       = 2'b00;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'b00;
            alu_ctrl     = 3'b000;
            ext_sign     = 1'b0;
            retire       = 1'b0;
            illegal      = 1'b0;
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected outputs go through a scoreboard queue.
module tb_mc_ctrl;
    import mc_defs::*;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_LUI  = 6'b001111;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_BAD  = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_NOP  = 6'b000000;
    localparam logic [5:0] JUNK   = 6'b111110;

    typedef struct {
        state_t     st;
        logic       rdy;
        logic       z;
        logic [5:0] o;
        logic [5:0] f;
        logic       alt;
        logic       dret;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] op = JUNK;
    logic [5:0] func = JUNK;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_src_a, ext_sign, retire, illegal;
    logic [1:0] pc_src, reg_dst, wd_sel, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [31:0] instr_cnt;
    logic [3:0] state;

    logic n_mem_req, n_mem_we, n_mem_addr_sel, n_ir_we, n_pc_we, n_reg_we, n_alu_src_a, n_ext_sign, n_retire, n_illegal;
    logic [1:0] n_pc_src, n_reg_dst, n_wd_sel, n_alu_src_b;
    logic [2:0] n_alu_ctrl;
    logic [1:0] n_instr_cnt;
    logic [3:0] n_state;

    logic [56:0] sb[$];
    int total = 0;
    int bad = 0;
    logic [31:0] exp_cnt = 32'd0;

    mc_ctrl #(.TRAP_ON_ILLEGAL(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_sign(ext_sign),
        .retire(retire), .instr_cnt(instr_cnt), .illegal(illegal), .state(state)
    );

    mc_ctrl #(.TRAP_ON_ILLEGAL(0), .CNT_W(2)) dut_nt (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr_sel(n_mem_addr_sel), .ir_we(n_ir_we),
        .pc_we(n_pc_we), .pc_src(n_pc_src), .reg_we(n_reg_we), .reg_dst(n_reg_dst), .wd_sel(n_wd_sel),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_ctrl(n_alu_ctrl), .ext_sign(n_ext_sign),
        .retire(n_retire), .instr_cnt(n_instr_cnt), .illegal(n_illegal), .state(n_state)
    );

    always #5 clk = ~clk;

    function automatic cyc_t cy(state_t st, logic rdy, logic z, logic [5:0] o, logic [5:0] f,
                                logic alt, logic dret);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.z = z; c.o = o; c.f = f; c.alt = alt; c.dret = dret;
        return c;
    endfunction

    // Expected Moore outputs per state; bit 1 is retire, bits 24:21 the state code
    function automatic logic [24:0] exp_outs(state_t st, logic rdy, logic z, logic alt, logic dret);
        logic mreq, mwe, asel, irw, pcw, rwe, srca, ext, ret, ill;
        logic [1:0] psrc, rdst, wds, srcb;
        logic [2:0] alu;
        {mreq, mwe, asel, irw, pcw, rwe, srca, ext, ret, ill} = '0;
        {psrc, rdst, wds, srcb} = '0;
        alu = 3'b000;
        case (st)
            S_FETCH:    begin mreq = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin srcb = 2'b11; ret = dret; end
            S_EXEC_R:   begin srca = 1; alu = alt ? 3'b001 : 3'b000; end
            S_WB_R:     begin rwe = 1; rdst = 2'b01; ret = 1; end
            S_EXEC_I:   begin srca = 1; srcb = 2'b10; alu = alt ? 3'b011 : 3'b010; end
            S_WB_I:     begin rwe = 1; ret = 1; end
            S_MEM_ADDR: begin srca = 1; srcb = 2'b10; ext = 1; end
            S_MEM_RD:   begin mreq = 1; asel = 1; end
            S_MEM_WB:   begin rwe = 1; wds = 2'b01; ret = 1; end
            S_MEM_WR:   begin mreq = 1; mwe = 1; asel = 1; ret = rdy; end
            S_BEQ:      begin srca = 1; alu = 3'b001; psrc = 2'b01; pcw = z; ret = 1; end
            S_JAL:      begin rwe = 1; rdst = 2'b10; wds = 2'b10; pcw = 1; psrc = 2'b10; ret = 1; end
            S_JR:       begin pcw = 1; psrc = 2'b11; ret = 1; end
            S_ILLEGAL:  begin ill = 1; end
            default:    begin end
        endcase
        return {4'(st), mreq, mwe, asel, irw, pcw, psrc, rwe, rdst, wds, srca, srcb, alu, ext, ret, ill};
    endfunction

    function automatic logic [24:0] obs_main();
        return {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel,
                alu_src_a, alu_src_b, alu_ctrl, ext_sign, retire, illegal};
    endfunction

    function automatic logic [24:0] obs_nt();
        return {n_state, n_mem_req, n_mem_we, n_mem_addr_sel, n_ir_we, n_pc_we, n_pc_src, n_reg_we,
                n_reg_dst, n_wd_sel, n_alu_src_a, n_alu_src_b, n_alu_ctrl, n_ext_sign, n_retire, n_illegal};
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expected result
    task automatic applyStimulus(input cyc_t c);
        @(negedge clk);
        op = c.o; func = c.f; zero = c.z; mem_ready = c.rdy;
        sb.push_back({exp_cnt, exp_outs(c.st, c.rdy, c.z, c.alt, c.dret)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic test_reset();
        logic [56:0] g;
        #2;
        g = {instr_cnt, obs_main()};
        total++;
        if (g !== {32'd0, 4'(S_FETCH), 21'd0}) begin
            bad++; $display("FAIL reset_initial got=%h exp=%h", g, {32'd0, 4'(S_FETCH), 21'd0});
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #2;
        g = {instr_cnt, obs_main()};
        total++;
        if (g !== {32'd0, 4'(S_FETCH), 21'd0}) begin
            bad++; $display("FAIL reset_held got=%h exp=%h", g, {32'd0, 4'(S_FETCH), 21'd0});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic test_addu_subu();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_R, F_ADDU, 0, 0));
        s.push_back(cy(S_EXEC_R, 1, 0, T_R, F_ADDU, 0, 0));
        s.push_back(cy(S_WB_R, 1, 0, T_R, F_ADDU, 0, 0));
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_R, F_SUBU, 0, 0));
        s.push_back(cy(S_EXEC_R, 1, 0, T_R, F_SUBU, 1, 0));
        s.push_back(cy(S_WB_R, 1, 0, T_R, F_SUBU, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL addu_subu cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_itype();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_ORI, 6'h15, 0, 0));
        s.push_back(cy(S_EXEC_I, 1, 0, T_ORI, 6'h15, 0, 0));
        s.push_back(cy(S_WB_I, 1, 0, T_ORI, 6'h15, 0, 0));
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_LUI, 6'h2A, 0, 0));
        s.push_back(cy(S_EXEC_I, 1, 0, T_LUI, 6'h2A, 1, 0));
        s.push_back(cy(S_WB_I, 1, 0, T_LUI, 6'h2A, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL itype cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_lw_wait();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_LW, 6'h04, 0, 0));
        s.push_back(cy(S_MEM_ADDR, 1, 0, T_LW, 6'h04, 0, 0));
        for (int k = 0; k < 3; k++) s.push_back(cy(S_MEM_RD, 0, 0, T_LW, 6'h04, 0, 0));
        s.push_back(cy(S_MEM_RD, 1, 0, T_LW, 6'h04, 0, 0));
        s.push_back(cy(S_MEM_WB, 1, 0, T_LW, 6'h04, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL lw_wait cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_sw_stall();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 0, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_FETCH, 0, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_SW, 6'h08, 0, 0));
        s.push_back(cy(S_MEM_ADDR, 1, 0, T_SW, 6'h08, 0, 0));
        s.push_back(cy(S_MEM_WR, 0, 0, T_SW, 6'h08, 0, 0));
        s.push_back(cy(S_MEM_WR, 1, 0, T_SW, 6'h08, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL sw_stall cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_beq();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_BEQ, 6'h3C, 0, 0));
        s.push_back(cy(S_BEQ, 1, 1, T_BEQ, 6'h3C, 0, 0));
        s.push_back(cy(S_FETCH, 1, 1, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 1, T_BEQ, 6'h01, 0, 0));
        s.push_back(cy(S_BEQ, 1, 0, T_BEQ, 6'h01, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL beq cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_jal_jr();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_JAL, 6'h15, 0, 0));
        s.push_back(cy(S_JAL, 1, 0, T_JAL, 6'h15, 0, 0));
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_R, F_JR, 0, 0));
        s.push_back(cy(S_JR, 1, 0, T_R, F_JR, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL jal_jr cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
    endtask

    task automatic test_back_to_back_nop_wrap();
        cyc_t s[$];
        logic [56:0] e, g;
        int nt_cnt = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
            s.push_back(cy(S_DECODE, 1, 0, T_R, F_NOP, 0, 1));
        end
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL nop cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) begin exp_cnt++; nt_cnt++; end
        end
        @(posedge clk);
        #1;
        total++;
        if (n_instr_cnt !== 2'(nt_cnt)) begin
            bad++; $display("FAIL cnt_wrap got=%0d exp=%0d", n_instr_cnt, 2'(nt_cnt));
        end
    endtask

    task automatic test_illegal();
        cyc_t s[$];
        logic [56:0] e, g;
        logic [24:0] gn, en;
        do_reset();
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 1, 0, T_BAD, 6'h3F, 0, 0));
        for (int k = 0; k < 20; k++) s.push_back(cy(S_ILLEGAL, 1, 0, T_BAD, 6'h3F, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
            if (i == 1 || i == 2) begin
                en = (i == 1) ? exp_outs(S_DECODE, 1, 0, 0, 1) : exp_outs(S_FETCH, 1, 0, 0, 0);
                gn = obs_nt();
                total++;
                if (gn !== en) begin bad++; $display("FAIL illegal_nop cyc%0d got=%h exp=%h", i, gn, en); end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        g = {instr_cnt, obs_main()};
        total++;
        if (g !== {32'd0, 4'(S_FETCH), 21'd0}) begin
            bad++; $display("FAIL illegal_reset got=%h exp=%h", g, {32'd0, 4'(S_FETCH), 21'd0});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        exp_cnt = 32'd0;
        #2;
        e = {exp_cnt, exp_outs(S_FETCH, 0, 0, 0, 0)};
        g = {instr_cnt, obs_main()};
        total++;
        if (g !== e) begin bad++; $display("FAIL illegal_release got=%h exp=%h", g, e); end
    endtask

    task automatic test_reset_mid_memwr();
        cyc_t s[$];
        logic [56:0] e, g;
        s.push_back(cy(S_FETCH, 1, 0, JUNK, JUNK, 0, 0));
        s.push_back(cy(S_DECODE, 0, 0, T_SW, 6'h10, 0, 0));
        s.push_back(cy(S_MEM_ADDR, 0, 0, T_SW, 6'h10, 0, 0));
        s.push_back(cy(S_MEM_WR, 0, 0, T_SW, 6'h10, 0, 0));
        s.push_back(cy(S_MEM_WR, 0, 0, T_SW, 6'h10, 0, 0));
        foreach (s[i]) begin
            applyStimulus(s[i]);
            #2;
            e = sb.pop_front(); g = {instr_cnt, obs_main()};
            total++;
            if (g !== e) begin bad++; $display("FAIL memwr_pre cyc%0d got=%h exp=%h", i, g, e); end
            if (e[1]) exp_cnt++;
        end
        #1;
        reset = 1'b0;
        #1;
        g = {instr_cnt, obs_main()};
        total++;
        if (g !== {32'd0, 4'(S_FETCH), 21'd0}) begin
            bad++; $display("FAIL memwr_reset got=%h exp=%h", g, {32'd0, 4'(S_FETCH), 21'd0});
        end
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 32'd0;
        applyStimulus(cy(S_FETCH, 0, 0, JUNK, JUNK, 0, 0));
        #2;
        e = sb.pop_front(); g = {instr_cnt, obs_main()};
        total++;
        if (g !== e) begin bad++; $display("FAIL memwr_release got=%h exp=%h", g, e); end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] mc_ctrl bench start");
        test_reset();
        test_addu_subu();
        test_itype();
        test_lw_wait();
        test_sw_stall();
        test_beq();
        test_jal_jr();
        test_back_to_back_nop_wrap();
        test_illegal();
        test_reset_mid_memwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
